// File: rtl/cpu_pkg.sv
// Shared opcode encodings, field widths and FSM state type for the fetch/decode slice.
package cpu_pkg;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned OPND_W = 5;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_LUT  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_BZ   = 4'b0010;
  localparam logic [OPC_W-1:0] OP_BNZ  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic branch_taken(input logic [OPC_W-1:0] op, input logic zf);
    return (op == OP_JMP) || (op == OP_BZ && zf) || (op == OP_BNZ && !zf);
  endfunction

endpackage

// File: rtl/next_pc.sv
// Next-PC adder: PC+1 or PC+sign-extended operand for taken branches, modulo 2^PC_W.
module next_pc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 10
) (
  input  logic [PC_W-1:0]   pc,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [OPND_W-1:0] operand,
  input  logic              zero_flag,
  output logic [PC_W-1:0]   pc_next
);

  logic [PC_W-1:0] offset;

  always_comb begin
    offset = {{(PC_W-OPND_W){operand[OPND_W-1]}}, operand};
    if (branch_taken(opcode, zero_flag)) begin
      pc_next = pc + offset;
    end else begin
      pc_next = pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: IDLE/RUN/DONE sequencer, PC register and registered decode outputs.
// Optional FETCH_CYCLE_COUNT_EN adds a saturating 16-bit RUN-cycle counter output.
module fetch_decode
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               zero_flag,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc_out,
  output logic               dec_valid,
  output logic [3:0]         opcode,
  output logic               acc_lut_en,
  output logic [4:0]         key,
  output logic               busy,
  output logic               done
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]        cycle_count
`endif
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_nxt;
  logic              dec_valid_q, dec_valid_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic              acc_lut_en_q, acc_lut_en_d;
  logic [OPND_W-1:0] key_q, key_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [OPC_W-1:0]  f_op;
  logic [OPND_W-1:0] f_operand;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0]       cnt_q, cnt_d;
`endif

  assign f_op      = instr_in[INSTR_W-1 -: OPC_W];
  assign f_operand = instr_in[OPND_W-1:0];

  next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc        (pc_q),
    .opcode    (f_op),
    .operand   (f_operand),
    .zero_flag (zero_flag),
    .pc_next   (pc_nxt)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    dec_valid_d  = 1'b0;
    acc_lut_en_d = 1'b0;
    opcode_d     = opcode_q;
    key_d        = key_q;
`ifdef FETCH_CYCLE_COUNT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      RUN: begin
`ifdef FETCH_CYCLE_COUNT_EN
        if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
`endif
        // A stall freezes PC and state, so a fetched branch/HALT simply waits.
        if (!stall) begin
          dec_valid_d  = 1'b1;
          opcode_d     = f_op;
          key_d        = f_operand;
          acc_lut_en_d = (f_op == OP_LUT);
          if (f_op == OP_HALT) begin
            state_d = DONE;
          end else begin
            pc_d = pc_nxt;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
`ifdef FETCH_CYCLE_COUNT_EN
          cnt_d   = '0;
`endif
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      dec_valid_q  <= 1'b0;
      opcode_q     <= '0;
      acc_lut_en_q <= 1'b0;
      key_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      dec_valid_q  <= dec_valid_d;
      opcode_q     <= opcode_d;
      acc_lut_en_q <= acc_lut_en_d;
      key_q        <= key_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef FETCH_CYCLE_COUNT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign pc_out     = pc_q;
  assign dec_valid  = dec_valid_q;
  assign opcode     = opcode_q;
  assign acc_lut_en = acc_lut_en_q;
  assign key        = key_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef FETCH_CYCLE_COUNT_EN
  assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: stimulus queues expected decodes, a negedge monitor checks them.
module tb_fetch_decode;

  logic       clk = 1'b0;
  logic       reset, start, stall, zero_flag;
  logic [8:0] instr_in;
  logic [9:0] pc_out;
  logic       dec_valid, acc_lut_en, busy, done;
  logic [3:0] opcode;
  logic [4:0] key;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  logic [8:0] rom [0:1023];

  typedef struct {
    logic [3:0] op;
    logic [4:0] key;
    logic       lut;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  assign instr_in = rom[pc_out];

  fetch_decode #(.PC_W(10), .INSTR_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .zero_flag  (zero_flag),
    .instr_in   (instr_in),
    .pc_out     (pc_out),
    .dec_valid  (dec_valid),
    .opcode     (opcode),
    .acc_lut_en (acc_lut_en),
    .key        (key),
    .busy       (busy),
    .done       (done)
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [4:0] k);
    exp_t e;
    e.op  = op;
    e.key = k;
    e.lut = (op == 4'b0001);
    exp_q.push_back(e);
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every valid decode must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (dec_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_issue", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("dec_opcode", opcode, e.op);
            check("dec_key", key, e.key);
            check("dec_lut_en", acc_lut_en, e.lut);
          end
        end else begin
          check("lut_en_when_invalid", acc_lut_en, 32'd0);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; zero_flag = 1'b0;
    clear_rom();
    tick();
    tick();
    reset = 1'b0;
    check("rst_pc", pc_out, 0);
    check("rst_valid", dec_valid, 0);
    check("rst_opcode", opcode, 0);
    check("rst_key", key, 0);
    check("rst_lut", acc_lut_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    mon_en = 1'b1;

    // LUT decode, BZ taken/not-taken, start ignored while running.
    clear_rom();
    rom[0] = {4'b0001, 5'd4};
    rom[1] = {4'b0000, 5'd1};
    rom[2] = {4'b0000, 5'd2};
    rom[3] = {4'b0010, 5'b11110};
    rom[4] = {4'b1111, 5'd0};
    push(4'h1, 5'd4); push(4'h0, 5'd1); push(4'h0, 5'd2); push(4'h2, 5'd30);
    push(4'h0, 5'd1); push(4'h0, 5'd2); push(4'h2, 5'd30); push(4'hF, 5'd0);
    zero_flag = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("t2_start_pc", pc_out, 0);
    check("t2_busy", busy, 1);
    check("t2_done", done, 0);
    tick();
    check("t2_pc1", pc_out, 1);
    check("t2_lut_valid", dec_valid, 1);
    check("t2_lut_en", acc_lut_en, 1);
    check("t2_lut_key", key, 4);
    start = 1'b1; tick(); start = 1'b0;
    check("t2_start_ignored_pc", pc_out, 2);
    tick();
    check("t2_pc3", pc_out, 3);
    tick();
    check("t2_bz_taken_pc", pc_out, 1);
    tick(); tick();
    zero_flag = 1'b0;
    tick();
    check("t2_bz_not_taken_pc", pc_out, 4);
    tick();
    check("t2_halt_done", done, 1);
    check("t2_halt_busy", busy, 0);
    check("t2_halt_pc", pc_out, 4);
    tick();
    check("t2_done_valid", dec_valid, 0);
    check("t2_done_pc", pc_out, 4);

    // BNZ backwards past zero, PC wrap at max, BZ self-loop.
    do_reset();
    clear_rom();
    rom[0]     = {4'b0011, 5'b11111};
    rom[10'h3FF] = {4'b0000, 5'd9};
    rom[1]     = {4'b0010, 5'd0};
    rom[2]     = {4'b1111, 5'd0};
    push(4'h3, 5'd31); push(4'h0, 5'd9); push(4'h3, 5'd31);
    push(4'h2, 5'd0); push(4'h2, 5'd0); push(4'h2, 5'd0); push(4'hF, 5'd0);
    zero_flag = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("t3_start_pc", pc_out, 0);
    tick();
    check("t3_bnz_neg_pc", pc_out, 10'h3FF);
    tick();
    check("t3_wrap_pc", pc_out, 0);
    zero_flag = 1'b1;
    tick();
    check("t3_bnz_not_taken_pc", pc_out, 1);
    tick();
    check("t3_selfloop_pc_a", pc_out, 1);
    tick();
    check("t3_selfloop_pc_b", pc_out, 1);
    zero_flag = 1'b0;
    tick();
    check("t3_exit_loop_pc", pc_out, 2);
    tick();
    check("t3_halt_done", done, 1);

    // JMP forward, stall held over a fetched HALT, restart from DONE.
    clear_rom();
    rom[0] = {4'b0100, 5'd5};
    rom[5] = {4'b1111, 5'd0};
    push(4'h4, 5'd5); push(4'hF, 5'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("t4_restart_pc", pc_out, 0);
    check("t4_restart_busy", busy, 1);
    check("t4_restart_done", done, 0);
    tick();
    check("t4_jmp_pc", pc_out, 5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_stall_pc", pc_out, 5);
      check("t4_stall_valid", dec_valid, 0);
      check("t4_stall_busy", busy, 1);
      check("t4_stall_opcode_hold", opcode, 4'h4);
      check("t4_stall_lut", acc_lut_en, 0);
    end
    stall = 1'b0;
    tick();
    check("t4_halt_valid", dec_valid, 1);
    check("t4_halt_opcode", opcode, 4'hF);
    check("t4_halt_done", done, 1);
    check("t4_halt_busy", busy, 0);
    check("t4_halt_pc", pc_out, 5);
    tick();
    check("t4_done_valid", dec_valid, 0);
    check("t4_done_pc", pc_out, 5);

    // Five-instruction program ending in HALT.
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = {4'b0000, 5'(i)};
    rom[4] = {4'b1111, 5'd0};
    for (int i = 0; i < 4; i++) push(4'h0, 5'(i));
    push(4'hF, 5'd0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check("t5_pc4", pc_out, 4);
    tick();
    check("t5_done", done, 1);
`ifdef FETCH_CYCLE_COUNT_EN
    check("t5_cycle_count", cycle_count, 5);
`endif
    tick();
    check("t5_done_hold", done, 1);
`ifdef FETCH_CYCLE_COUNT_EN
    check("t5_cycle_count_hold", cycle_count, 5);
`endif

    // Reset mid-run beats start and stall in the same cycle.
    clear_rom();
    for (int i = 0; i < 10; i++) rom[i] = {4'b0000, 5'(i)};
    for (int i = 0; i < 7; i++) push(4'h0, 5'(i));
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    check("t6_pc7", pc_out, 7);
    check("t6_key_before_reset", key, 6);
    reset = 1'b1; start = 1'b1; stall = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; stall = 1'b0;
    check("t6_rst_pc", pc_out, 0);
    check("t6_rst_valid", dec_valid, 0);
    check("t6_rst_opcode", opcode, 0);
    check("t6_rst_key", key, 0);
    check("t6_rst_lut", acc_lut_en, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
`ifdef FETCH_CYCLE_COUNT_EN
    check("t6_rst_cycle_count", cycle_count, 0);
`endif
    tick();
    check("t6_idle_pc", pc_out, 0);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_valid", dec_valid, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("t6_restart_pc", pc_out, 0);
    check("t6_restart_busy", busy, 1);
    reset = 1'b1; tick(); reset = 1'b0;

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program-counter width in bits.
REQ-002 SHALL have parameter INSTR_W, default 9, meaning instruction width as {opcode[8:5], operand[4:0]}.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle pulse that launches a program run.
REQ-006 SHALL have port stall, input, 1, hold request from downstream stages.
REQ-007 SHALL have port zero_flag, input, 1, accumulator-zero flag from the ALU.
REQ-008 SHALL have port instr_in, input, INSTR_W, instruction read combinationally from ROM at pc_out.
REQ-009 SHALL have port pc_out, output, PC_W, current program counter.
REQ-010 SHALL have port dec_valid, output, 1, registered decoded instruction is valid this cycle.
REQ-011 SHALL have port opcode, output, 4, registered opcode.
REQ-012 SHALL have port acc_lut_en, output, 1, registered enable to the accumulator-constant LUT.
REQ-013 SHALL have port key, output, 5, registered LUT key (operand field).
REQ-014 SHALL have ports busy and done, output, 1 each, run-in-progress and program-halted indicators.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-016 IDLE/DONE + start=1 SHALL go to RUN with pc_out=0 on the next cycle; start in RUN SHALL be ignored.
REQ-017 In RUN with stall=0, the instruction at pc_out SHALL appear on opcode/key/acc_lut_en with dec_valid=1 exactly one cycle later.
REQ-018 acc_lut_en SHALL be 1 only for opcode OP_LUT (4'b0001) with dec_valid=1; key SHALL equal operand for every valid instruction.
REQ-019 Non-control opcodes SHALL advance PC by 1, modulo 2^PC_W (wrap from max to 0 without error).
REQ-020 OP_BZ (4'b0010) with zero_flag=1, OP_BNZ (4'b0011) with zero_flag=0, and OP_JMP (4'b0100) SHALL set PC to PC + sign-extended operand, modulo 2^PC_W; not-taken branches advance by 1; no delay slot.
REQ-021 Branch offset 0 SHALL be legal (self-loop, PC holds while still issuing the instruction each cycle).
REQ-022 OP_HALT (4'b1111) SHALL be issued as a valid decode, then the FSM SHALL enter DONE and hold pc_out.
REQ-023 stall=1 in RUN SHALL hold PC and FSM state and force dec_valid=0 and acc_lut_en=0 next cycle; other decode outputs hold.
REQ-024 stall=1 coincident with a fetched branch or HALT SHALL defer that instruction entirely until stall=0.
REQ-025 In IDLE and DONE, dec_valid and acc_lut_en SHALL be 0.

Reset
REQ-026 reset=1 SHALL, on the next edge and regardless of state or start/stall, set state=IDLE, pc_out=0, dec_valid=0, opcode=0, acc_lut_en=0, key=0, busy=0, done=0.
REQ-027 reset SHALL take priority over start in the same cycle.

Configuration
REQ-028 With macro FETCH_CYCLE_COUNT_EN defined, SHALL add output cycle_count (16 bits): cleared on reset and on accepted start, +1 per RUN cycle, saturating at 16'hFFFF, held in DONE.
REQ-029 Without FETCH_CYCLE_COUNT_EN, the port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Opcode constants (OP_NOP, OP_LUT, OP_BZ, OP_BNZ, OP_JMP, OP_HALT) and the FSM state enum SHALL live in shared package cpu_pkg.
REQ-031 Next-PC computation SHALL be a sub-module next_pc (inputs pc, opcode, operand, zero_flag; output next pc); FSM and decode registers stay in fetch_decode.

Verification
REQ-032 reset, start; ROM[0]=OP_LUT key 5'd4 -> cycle after first RUN cycle: dec_valid=1, acc_lut_en=1, key=4.
REQ-033 ROM[3]=OP_BZ offset -2, zero_flag=1 -> next pc_out=1; zero_flag=0 -> next pc_out=4.
REQ-034 PC at 10'h3FF executing OP_NOP -> next pc_out=0.
REQ-035 stall held 3 cycles at pc=5 holding OP_HALT -> pc stays 5, dec_valid=0, busy=1; stall release -> HALT issued, then done=1.
REQ-036 reset asserted mid-run at pc=7 -> next cycle all outputs zero, state IDLE; later start -> pc_out=0.
REQ-037 FETCH_CYCLE_COUNT_EN: 5-instruction program ending in HALT -> cycle_count=5 in DONE, unchanged while in DONE.
